mem_access_ctrl: RTL and testbench

- CPU-side initiator for the 512x32 memory subsystem. Memory reads are combinational; memory writes are synchronous.
- Accepts one load/store request at a time from the datapath over a valid/ready handshake.
- Holds the address in an internal MAR and the data in an internal MDR, and drives the memory's Address, Datain and Write inputs.
- Returns read data or write completion over a valid/ready response handshake.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_access_ctrl_if.sv | 28 ++
 rtl/mem_mar_mdr.sv | 37 +++
 rtl/mem_access_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the 512x32 memory subsystem and its access controller.
package mem_pkg;

  localparam int unsigned MEM_ADDR_W = 9;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_DEPTH  = 512;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP,
    VERIFY
  } mem_state_t;

  // Any set bit above the memory address field means the word does not exist.
  function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned addr_w);
    return (addr >> addr_w) != 32'd0;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Datapath-side request/response handshake of the memory access controller.
interface mem_access_ctrl_if
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = MEM_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_mar_mdr.sv
// Memory address (MAR) and memory data (MDR) registers with independent load enables.
module mem_mar_mdr #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mar_load_i,
  input  logic [ADDR_W-1:0] mar_i,
  input  logic              mdr_load_i,
  input  logic [DATA_W-1:0] mdr_i,
  output logic [ADDR_W-1:0] mar_o,
  output logic [DATA_W-1:0] mdr_o
);

  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;

  always_comb begin
    mar_d = mar_load_i ? mar_i : mar_q;
    mdr_d = mdr_load_i ? mdr_i : mdr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mar_q <= '0;
      mdr_q <= '0;
    end else begin
      mar_q <= mar_d;
      mdr_q <= mdr_d;
    end
  end

  assign mar_o = mar_q;
  assign mdr_o = mdr_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store initiator for the 512x32 memory.
// Define MEM_WRITE_VERIFY_EN to read back every store and flag a mismatch in rsp_err.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = MEM_ADDR_W,
  parameter int unsigned DATA_W      = MEM_DATA_W,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_access_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_dataout
);

  localparam logic [3:0] WaitLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mem_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              wr_q, wr_d;
  logic              mar_load, mdr_load;
  logic [DATA_W-1:0] mdr_in;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              addr_oor;

  assign addr_oor = addr_out_of_range(bus.req_addr, ADDR_W);

  mem_mar_mdr #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mar_mdr (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .mar_load_i (mar_load),
    .mar_i      (bus.req_addr[ADDR_W-1:0]),
    .mdr_load_i (mdr_load),
    .mdr_i      (mdr_in),
    .mar_o      (mar),
    .mdr_o      (mdr)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    wr_d     = wr_q;
    mar_load = 1'b0;
    mdr_load = 1'b0;
    mdr_in   = bus.req_wdata;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          mar_load = 1'b1;
          // A load keeps the old MDR so a rejected load returns it untouched.
          mdr_load = bus.req_write;
          wr_d     = bus.req_write;
          err_d    = addr_oor;
          if (addr_oor) begin
            state_d = RESP;
          end else if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WaitLoad;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACCESS: begin
        if (!wr_q) begin
          mdr_load = 1'b1;
          mdr_in   = mem_dataout;
          state_d  = RESP;
        end else begin
`ifdef MEM_WRITE_VERIFY_EN
          state_d = VERIFY;
`else
          state_d = RESP;
`endif
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      VERIFY: begin
`ifdef MEM_WRITE_VERIFY_EN
        if (mem_dataout != mdr) err_d = 1'b1;
        state_d = RESP;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
    end
  end

  // Decoded from state so an asynchronous reset kills a pending write at once.
  assign mem_write     = (state_q == ACCESS) && wr_q;
  assign mem_addr      = mar;
  assign mem_datain    = mdr;
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = (state_q == RESP) && err_q;
  assign bus.rsp_rdata = mdr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance with no wait cycles, one with three,
// each backed by a combinational-read / synchronous-write memory model.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic corrupt = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.DATA_W(32)) b0 ();
  mem_access_ctrl_if #(.DATA_W(32)) b3 ();

  logic [8:0]  mem_addr0, mem_addr3;
  logic [31:0] mem_datain0, mem_datain3, mem_dataout0, mem_dataout3;
  logic        mem_write0, mem_write3;
  logic [31:0] m0 [MEM_DEPTH];
  logic [31:0] m3 [MEM_DEPTH];

  assign mem_dataout0 = m0[mem_addr0] ^ {31'd0, corrupt};
  assign mem_dataout3 = m3[mem_addr3];

  always @(posedge clk) if (mem_write0) m0[mem_addr0] <= mem_datain0;
  always @(posedge clk) if (mem_write3) m3[mem_addr3] <= mem_datain3;

  mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (b0),
    .mem_addr    (mem_addr0),
    .mem_datain  (mem_datain0),
    .mem_write   (mem_write0),
    .mem_dataout (mem_dataout0)
  );

  mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(3)) dut3 (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (b3),
    .mem_addr    (mem_addr3),
    .mem_datain  (mem_datain3),
    .mem_write   (mem_write3),
    .mem_dataout (mem_dataout3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One complete transaction on dut0; oor marks a request that skips the memory.
  task automatic txn0(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic oor, input logic exp_err);
    @(negedge clk);
    b0.req_valid = 1'b1;
    b0.req_write = wr;
    b0.req_addr  = addr;
    b0.req_wdata = wdata;
    chk("idle_ready", 32'(b0.req_ready), 32'd1);
    @(negedge clk);
    b0.req_valid = 1'b0;
    if (!oor) begin
      chk("acc_memwr", 32'(mem_write0), 32'(wr));
      chk("acc_addr", 32'(mem_addr0), {23'd0, addr[8:0]});
      chk("acc_rspv", 32'(b0.rsp_valid), 32'd0);
      if (wr) begin
        chk("acc_din", mem_datain0, wdata);
`ifdef MEM_WRITE_VERIFY_EN
        @(negedge clk);
        chk("ver_memwr", 32'(mem_write0), 32'd0);
        chk("ver_rspv", 32'(b0.rsp_valid), 32'd0);
`endif
      end
      @(negedge clk);
    end
    chk("rsp_valid", 32'(b0.rsp_valid), 32'd1);
    chk("rsp_err", 32'(b0.rsp_err), 32'(exp_err));
    chk("rsp_rdata", b0.rsp_rdata, exp_rdata);
    chk("rsp_memwr", 32'(mem_write0), 32'd0);
    chk("rsp_req_ready", 32'(b0.req_ready), 32'd0);
    b0.rsp_ready = 1'b1;
    @(negedge clk);
    b0.rsp_ready = 1'b0;
    chk("post_rspv", 32'(b0.rsp_valid), 32'd0);
    chk("post_ready", 32'(b0.req_ready), 32'd1);
  endtask

  // Load on dut3: three wait cycles, ACCESS in cycle 4, response in cycle 5.
  task automatic load3(input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    b3.req_valid = 1'b1;
    b3.req_write = 1'b0;
    b3.req_addr  = addr;
    b3.req_wdata = 32'd0;
    @(negedge clk);
    b3.req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk("w3_wait_rspv", 32'(b3.rsp_valid), 32'd0);
      chk("w3_wait_ready", 32'(b3.req_ready), 32'd0);
      @(negedge clk);
    end
    chk("w3_acc_addr", 32'(mem_addr3), {23'd0, addr[8:0]});
    chk("w3_acc_rspv", 32'(b3.rsp_valid), 32'd0);
    chk("w3_acc_memwr", 32'(mem_write3), 32'd0);
    @(negedge clk);
    chk("w3_rspv", 32'(b3.rsp_valid), 32'd1);
    chk("w3_rdata", b3.rsp_rdata, exp);
    chk("w3_err", 32'(b3.rsp_err), 32'd0);
    b3.rsp_ready = 1'b1;
    @(negedge clk);
    b3.rsp_ready = 1'b0;
    chk("w3_post_ready", 32'(b3.req_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_DEPTH); i++) begin
      m0[i] = 32'd0;
      m3[i] = 32'd0;
    end
    m0[0]     = 32'h00C0FFEE;
    m3[0]     = 32'h11112222;
    m3[9'h1FF] = 32'h0BADCAFE;
    b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = '0; b0.req_wdata = '0;
    b0.rsp_ready = 1'b0;
    b3.req_valid = 1'b0; b3.req_write = 1'b0; b3.req_addr = '0; b3.req_wdata = '0;
    b3.rsp_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(b0.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(b0.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(b0.rsp_err), 32'd0);
    chk("rst_mem_write", 32'(mem_write0), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr0), 32'd0);
    chk("rst_mem_datain", mem_datain0, 32'd0);
    chk("rst_w3_ready", 32'(b3.req_ready), 32'd1);
    reset_n = 1'b1;

    // Store, load back, out-of-range load and store
    txn0(1'b1, 32'h005, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("mem5_after_store", m0[5], 32'hDEADBEEF);
    txn0(1'b0, 32'h005, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("mem5_after_load", m0[5], 32'hDEADBEEF);
    txn0(1'b0, 32'h200, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1);
    txn0(1'b1, 32'h80000005, 32'h99, 32'h99, 1'b1, 1'b1);
    chk("mem5_after_oor", m0[5], 32'hDEADBEEF);

    // Top address then address 0
    txn0(1'b1, 32'h1FF, 32'h600DF00D, 32'h600DF00D, 1'b0, 1'b0);
    txn0(1'b0, 32'h000, 32'h0, 32'h00C0FFEE, 1'b0, 1'b0);
    txn0(1'b0, 32'h1FF, 32'h0, 32'h600DF00D, 1'b0, 1'b0);

    // Response backpressure with a second request held throughout
    @(negedge clk);
    b0.req_valid = 1'b1; b0.req_write = 1'b0; b0.req_addr = 32'h005; b0.req_wdata = 32'h0;
    @(negedge clk);
    chk("bp_acc_memwr", 32'(mem_write0), 32'd0);
    b0.req_write = 1'b1; b0.req_addr = 32'h010; b0.req_wdata = 32'h12345678;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rspv", 32'(b0.rsp_valid), 32'd1);
      chk("bp_rdata", b0.rsp_rdata, 32'hDEADBEEF);
      chk("bp_req_ready", 32'(b0.req_ready), 32'd0);
      chk("bp_memwr", 32'(mem_write0), 32'd0);
      @(negedge clk);
    end
    b0.rsp_ready = 1'b1;
    @(negedge clk);
    b0.rsp_ready = 1'b0;
    chk("bp_idle_ready", 32'(b0.req_ready), 32'd1);
    chk("bp_idle_rspv", 32'(b0.rsp_valid), 32'd0);
    @(negedge clk);
    b0.req_valid = 1'b0;
    chk("bp2_memwr", 32'(mem_write0), 32'd1);
    chk("bp2_addr", 32'(mem_addr0), 32'h010);
    chk("bp2_din", mem_datain0, 32'h12345678);
`ifdef MEM_WRITE_VERIFY_EN
    @(negedge clk);
`endif
    @(negedge clk);
    chk("bp2_rspv", 32'(b0.rsp_valid), 32'd1);
    chk("bp2_rdata", b0.rsp_rdata, 32'h12345678);
    b0.rsp_ready = 1'b1;
    @(negedge clk);
    b0.rsp_ready = 1'b0;
    chk("mem10_after_store", m0[9'h010], 32'h12345678);

`ifdef MEM_WRITE_VERIFY_EN
    // Read-back mismatch flags the store
    corrupt = 1'b1;
    txn0(1'b1, 32'h007, 32'h55, 32'h55, 1'b0, 1'b1);
    corrupt = 1'b0;
`endif

    // Reset in the middle of a store's ACCESS cycle
    @(negedge clk);
    b0.req_valid = 1'b1; b0.req_write = 1'b1; b0.req_addr = 32'h0AA; b0.req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    b0.req_valid = 1'b0;
    chk("mid_acc_memwr", 32'(mem_write0), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_memwr", 32'(mem_write0), 32'd0);
    chk("mid_rst_ready", 32'(b0.req_ready), 32'd1);
    chk("mid_rst_addr", 32'(mem_addr0), 32'd0);
    chk("mid_rst_din", mem_datain0, 32'd0);
    chk("mid_rst_rspv", 32'(b0.rsp_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_mem", m0[9'h0AA], 32'd0);
    @(negedge clk);
    chk("mid_rst_rspv2", 32'(b0.rsp_valid), 32'd0);
    chk("mid_rst_ready2", 32'(b0.req_ready), 32'd1);

    // Three wait cycles
    load3(32'h1FF, 32'h0BADCAFE);
    load3(32'h000, 32'h11112222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
